ap_ctrl_perf_monitor: RTL and testbench

Synthesisable, multi-channel performance monitor for HLS blocks using the `ap_ctrl_chain` handshake. It watches `ap_start`, `ap_ready`, `ap_done` and `ap_continue` on NUM_CH kernels, for example `fir_filter` instances. Per channel it keeps transaction count, latency (last/min/max), initiation interval, output-stall cycles and busy cycles. It sits beside the kernels in the top level, and software or the bench reads it through a registered read port instead of dumping CSV files from simulation.

---
 rtl/ap_ctrl_perf_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_perf_monitor.sv
// ---------------------------------------------------------------------------
// ap_ctrl_perf_monitor
//   Per-channel performance monitor for HLS kernels using the ap_ctrl_chain
//   handshake. Each channel tracks transaction count, latency (last/min/max),
//   initiation interval, output-stall cycles and busy cycles. All statistics
//   saturate at 2^CNT_W-1, and sat_flags records which ones have reached
//   that ceiling. Statistics are read back through a one-cycle registered
//   read port.
//
// Parameters
//   NUM_CH  monitored channels (1..16)
//   CNT_W   statistic width (8..48)
//
// Ports
//   clock        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   clear        synchronous statistics clear (FSMs and running counters kept)
//   ap_start     per-channel ap_start
//   ap_ready     per-channel ap_ready
//   ap_done      per-channel ap_done
//   ap_continue  per-channel ap_continue (tie high for ap_ctrl_hs kernels)
//   rd_en        read request; data returned on the next cycle
//   rd_ch        channel index for the read (out-of-range reads return 0)
//   rd_sel       0 txn_count, 1 last_lat, 2 min_lat, 3 max_lat, 4 last_ii,
//                5 stall_total, 6 busy_total, 7 sat_flags (zero-extended)
//   rd_valid     read data valid
//   rd_data      read data
//   busy         channel FSM is not in IDLE
// ---------------------------------------------------------------------------
module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_en,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  // Every statistic of every channel, indexed by [channel][rd_sel].
  logic [CNT_W-1:0] stat_bus [NUM_CH][8];
  logic [CNT_W-1:0] rd_mux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] lat_cnt, ii_cnt;
    logic [CNT_W-1:0] txn_count, last_lat, min_lat, max_lat;
    logic [CNT_W-1:0] last_ii, stall_total, busy_total;
    logic [6:0]       sat_flags, sat_set;
    logic [CNT_W-1:0] done_lat;
    logic             busy_ch, done_evt, stall_evt, ready_evt, ii_evt;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
    end

    // Next-state logic. A start coinciding with done is a zero-latency
    // (combinational) transaction and exits exactly like a RUN completion.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: begin
          if (ap_start[g]) begin
            if (ap_done[g]) state_d = ap_continue[g] ? IDLE : DONE_WAIT;
            else            state_d = RUN;
          end
        end
        RUN:       if (ap_done[g]) state_d = ap_continue[g] ? IDLE : DONE_WAIT;
        DONE_WAIT: if (ap_continue[g]) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end

    // Output / event decode.
    always_comb begin
      busy_ch   = (state_q != IDLE);
      done_evt  = ap_done[g] && ((state_q == RUN) || (state_q == IDLE && ap_start[g]));
      done_lat  = (state_q == RUN) ? lat_cnt : '0;
      stall_evt = (state_q == DONE_WAIT) && !ap_continue[g];
      ready_evt = ap_start[g] && ap_ready[g];
      // ii_cnt is zero only before the first ready event of this channel.
      ii_evt    = ready_evt && (ii_cnt != '0);

      // A flag bit sets when its statistic is written with the ceiling value.
      sat_set    = '0;
      sat_set[0] = done_evt && (txn_count >= CNT_MAX - CNT_ONE);
      sat_set[1] = done_evt && (done_lat == CNT_MAX);
      sat_set[2] = done_evt && (done_lat == CNT_MAX) && (min_lat == CNT_MAX);
      sat_set[3] = done_evt && (done_lat == CNT_MAX);
      sat_set[4] = ii_evt && (ii_cnt == CNT_MAX);
      sat_set[5] = stall_evt && (stall_total >= CNT_MAX - CNT_ONE);
      sat_set[6] = busy_ch && (busy_total >= CNT_MAX - CNT_ONE);
    end

    // Running counters: not affected by clear, so in-flight latency and the
    // interval in progress stay correct across a statistics clear.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        lat_cnt <= '0;
        ii_cnt  <= '0;
      end else begin
        if (state_q == IDLE && ap_start[g])     lat_cnt <= CNT_ONE;
        else if (state_q == RUN && !ap_done[g]) lat_cnt <= sat_inc(lat_cnt);

        if (ready_evt)            ii_cnt <= CNT_ONE;
        else if (ii_cnt != '0)    ii_cnt <= sat_inc(ii_cnt);
      end
    end

    // Statistics. Clear has priority over any update in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        txn_count   <= '0;
        last_lat    <= '0;
        min_lat     <= CNT_MAX;
        max_lat     <= '0;
        last_ii     <= '0;
        stall_total <= '0;
        busy_total  <= '0;
        sat_flags   <= '0;
      end else if (clear) begin
        txn_count   <= '0;
        last_lat    <= '0;
        min_lat     <= CNT_MAX;
        max_lat     <= '0;
        last_ii     <= '0;
        stall_total <= '0;
        busy_total  <= '0;
        sat_flags   <= '0;
      end else begin
        if (done_evt) begin
          txn_count <= sat_inc(txn_count);
          last_lat  <= done_lat;
          if (done_lat < min_lat) min_lat <= done_lat;
          if (done_lat > max_lat) max_lat <= done_lat;
        end
        if (ii_evt)    last_ii     <= ii_cnt;
        if (stall_evt) stall_total <= sat_inc(stall_total);
        if (busy_ch)   busy_total  <= sat_inc(busy_total);
        sat_flags <= sat_flags | sat_set;
      end
    end

    assign busy[g]        = busy_ch;
    assign stat_bus[g][0] = txn_count;
    assign stat_bus[g][1] = last_lat;
    assign stat_bus[g][2] = min_lat;
    assign stat_bus[g][3] = max_lat;
    assign stat_bus[g][4] = last_ii;
    assign stat_bus[g][5] = stall_total;
    assign stat_bus[g][6] = busy_total;
    assign stat_bus[g][7] = {{(CNT_W-7){1'b0}}, sat_flags};
  end

  // Read select; channels beyond NUM_CH fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == 4'(c)) rd_mux = stat_bus[c][rd_sel];
    end
  end

  // Registered read port: sampling before this edge's statistic updates
  // means a read coinciding with an update returns the pre-update value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_perf_monitor
//   Scoreboard bench for ap_ctrl_perf_monitor (NUM_CH=4, CNT_W=8 so that
//   saturation is reachable). Directed transactions and randomized traffic
//   drive all channels; a cycle-level reference model computes statistics
//   from event times (latency = done cycle - start cycle, II = distance
//   between ready events). Each read pushes its expected data into a queue
//   and a separate monitor pops and compares whenever the DUT answers.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_perf_monitor;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           clr;
  logic [NCH-1:0] st, rdy, dn, cont;
  logic           rd_en;
  logic [3:0]     rd_ch_i;
  logic [2:0]     rd_sel_i;
  logic           rd_valid;
  logic [CW-1:0]  rd_data;
  logic [NCH-1:0] busy;

  ap_ctrl_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clr),
    .ap_start   (st),
    .ap_ready   (rdy),
    .ap_done    (dn),
    .ap_continue(cont),
    .rd_en      (rd_en),
    .rd_ch      (rd_ch_i),
    .rd_sel     (rd_sel_i),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int    due;
    int    val;
    string name;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 transaction in progress, 2 finished but output held
  int        phase      [NCH];
  int        start_cyc  [NCH];
  int        last_ready [NCH];
  bit        ready_seen [NCH];
  int        m_txn [NCH], m_last [NCH], m_min [NCH], m_max [NCH];
  int        m_ii [NCH], m_stall [NCH], m_busy [NCH];
  bit [6:0]  m_flags [NCH];
  bit        k_mode = 1'b0;
  int        k_val  = 0;

  function automatic int clampi(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic model_clear_stats(input int c);
    m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAX; m_max[c] = 0;
    m_ii[c] = 0; m_stall[c] = 0; m_busy[c] = 0; m_flags[c] = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      model_clear_stats(c);
      phase[c] = 0; start_cyc[c] = 0; last_ready[c] = 0; ready_seen[c] = 1'b0;
    end
  endtask

  function automatic int model_read(input int ch, input int sel);
    if (ch >= NCH) return 0;
    case (sel)
      0: return m_txn[ch];
      1: return m_last[ch];
      2: return m_min[ch];
      3: return m_max[ch];
      4: return m_ii[ch];
      5: return m_stall[ch];
      6: return m_busy[ch];
      default: return int'(m_flags[ch]);
    endcase
  endfunction

  // Apply the inputs currently driven for one clock of channel c.
  task automatic model_step(input int c);
    bit done_now, stall_now, busy_now, ready_now;
    int lat;
    busy_now  = (phase[c] != 0);
    done_now  = dn[c] && (phase[c] == 1 || (phase[c] == 0 && st[c]));
    stall_now = (phase[c] == 2) && !cont[c];
    ready_now = st[c] && rdy[c];
    lat       = (phase[c] == 1) ? clampi(cyc - start_cyc[c]) : 0;

    if (clr) model_clear_stats(c);
    else begin
      if (done_now) begin
        m_txn[c] = clampi(m_txn[c] + 1);
        if (m_txn[c] == MAX) m_flags[c][0] = 1'b1;
        m_last[c] = lat;
        if (lat < m_min[c]) m_min[c] = lat;
        if (lat > m_max[c]) m_max[c] = lat;
        if (lat == MAX) begin
          m_flags[c][1] = 1'b1;
          m_flags[c][3] = 1'b1;
          if (m_min[c] == MAX) m_flags[c][2] = 1'b1;
        end
      end
      if (ready_now && ready_seen[c]) begin
        m_ii[c] = clampi(cyc - last_ready[c]);
        if (m_ii[c] == MAX) m_flags[c][4] = 1'b1;
      end
      if (stall_now) begin
        m_stall[c] = clampi(m_stall[c] + 1);
        if (m_stall[c] == MAX) m_flags[c][5] = 1'b1;
      end
      if (busy_now) begin
        m_busy[c] = clampi(m_busy[c] + 1);
        if (m_busy[c] == MAX) m_flags[c][6] = 1'b1;
      end
    end

    if (ready_now) begin
      last_ready[c] = cyc;
      ready_seen[c] = 1'b1;
    end

    if (phase[c] == 0 && st[c]) begin
      if (dn[c]) phase[c] = cont[c] ? 0 : 2;
      else begin
        phase[c]     = 1;
        start_cyc[c] = cyc;
      end
    end else if (phase[c] == 1 && dn[c]) phase[c] = cont[c] ? 0 : 2;
    else if (phase[c] == 2 && cont[c])   phase[c] = 0;
  endtask

  // One clock: queue the expected read response, advance the model, step
  // the DUT, then compare busy a little after the edge.
  task automatic cycle();
    logic [NCH-1:0] exp_busy;
    if (rd_en) begin
      exp_t e;
      e.due  = cyc + 1;
      e.val  = k_mode ? k_val : model_read(int'(rd_ch_i), int'(rd_sel_i));
      e.name = $sformatf("rd ch%0d sel%0d", rd_ch_i, rd_sel_i);
      sb.push_back(e);
    end
    for (int c = 0; c < NCH; c++) model_step(c);
    @(posedge clock);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) exp_busy[c] = (phase[c] != 0);
    check("busy", busy, exp_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rd(input int ch, input int sel);
    rd_en = 1'b1; rd_ch_i = 4'(ch); rd_sel_i = 3'(sel);
    cycle();
    rd_en = 1'b0;
  endtask

  // Read whose expected value is a fixed constant rather than the model.
  task automatic rd_k(input int ch, input int sel, input int val);
    k_mode = 1'b1; k_val = val;
    rd(ch, sel);
    k_mode = 1'b0;
  endtask

  // Transaction on one channel: start+ready, done after lat cycles, then
  // ap_continue held low for stall cycles before being released.
  task automatic txn(input int ch, input int lat, input int stall);
    st[ch] = 1'b1; rdy[ch] = 1'b1; dn[ch] = (lat == 0); cont[ch] = (stall == 0);
    cycle();
    st[ch] = 1'b0; rdy[ch] = 1'b0;
    if (lat > 0) begin
      dn[ch] = 1'b0;
      for (int i = 1; i < lat; i++) cycle();
      dn[ch] = 1'b1; cont[ch] = (stall == 0);
      cycle();
    end
    dn[ch] = 1'b0; cont[ch] = 1'b0;
    for (int i = 0; i < stall; i++) cycle();
    cont[ch] = 1'b1;
    if (stall > 0) cycle();
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " valid"}, rd_valid, 1);
        check(e.name, rd_data, e.val);
      end else if (rd_valid === 1'b1) begin
        check("spurious rd_valid", rd_valid, 0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_ch_i = '0; rd_sel_i = '0;
    st = '0; rdy = '0; dn = '0; cont = '1;
    model_reset();
    repeat (2) @(posedge clock);
    #3;
    check("reset busy", busy, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    reset_n = 1'b1;

    // Reset values of every statistic on ch0.
    rd_k(0, 0, 0); rd_k(0, 1, 0); rd_k(0, 2, MAX); rd_k(0, 3, 0);
    rd_k(0, 4, 0); rd_k(0, 5, 0); rd_k(0, 6, 0); rd_k(0, 7, 0);

    // Single transaction, latency 7.
    txn(0, 7, 0);
    rd_k(0, 0, 1); rd_k(0, 1, 7); rd_k(0, 2, 7); rd_k(0, 3, 7);
    rd_k(0, 5, 0); rd_k(0, 6, 7);

    // Three transactions with latencies 4, 9, 6.
    txn(1, 4, 0); txn(1, 9, 0); txn(1, 6, 0);
    rd_k(1, 0, 3); rd_k(1, 1, 6); rd_k(1, 2, 4); rd_k(1, 3, 9);

    // Ready events spaced 6 then 3 cycles (zero-latency transactions).
    txn(2, 0, 0);
    rd_k(2, 4, 0);
    idle(4);
    txn(2, 0, 0);
    idle(2);
    txn(2, 0, 0);
    rd_k(2, 4, 3);

    // Output stall of 5 cycles: busy for 2 run + 5 stall + 1 release cycles.
    txn(3, 2, 5);
    rd_k(3, 5, 5); rd_k(3, 6, 8); rd_k(3, 1, 2);

    // Saturation: 300 more transactions on ch0. busy_total (7 + 300) also
    // saturates, so flags = bit0 | bit6.
    for (int i = 0; i < 300; i++) txn(0, 1, 0);
    rd_k(0, 0, MAX); rd_k(0, 7, 'h41); rd(0, 6);
    clr = 1'b1; cycle(); clr = 1'b0;
    rd_k(0, 0, 0); rd_k(0, 7, 0); rd_k(0, 2, MAX);

    // Reset in the middle of a running transaction.
    st[0] = 1'b1; rdy[0] = 1'b1; dn[0] = 1'b0; cont[0] = 1'b1;
    cycle();
    st[0] = 1'b0; rdy[0] = 1'b0;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check("mid-run reset busy", busy, 0);
    model_reset();
    #2 reset_n = 1'b1;
    rd_k(0, 0, 0); rd_k(0, 1, 0); rd_k(0, 2, MAX); rd_k(1, 0, 0);
    txn(0, 3, 0);
    rd_k(0, 1, 3);
    rd_k(NCH, 0, 0);
    rd_k(15, 7, 0);

    // Randomized traffic on all channels with concurrent reads and clears.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        st[c]   = ($urandom_range(0, 2) == 0);
        rdy[c]  = ($urandom_range(0, 1) == 0);
        dn[c]   = ($urandom_range(0, 2) == 0);
        cont[c] = ($urandom_range(0, 3) != 0);
      end
      clr      = ($urandom_range(0, 199) == 0);
      rd_en    = ($urandom_range(0, 1) == 0);
      rd_ch_i  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NCH - 1));
      rd_sel_i = 3'($urandom_range(0, 7));
      cycle();
    end

    // Quiesce and read back every statistic of every channel.
    st = '0; rdy = '0; dn = '0; cont = '1; clr = 1'b0; rd_en = 1'b0;
    idle(2);
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 8; s++) rd(c, s);
    idle(3);
    check("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
